// File: rtl/nonlinear_pkg.sv
// Shared types for the nonlinear command path: operation codes, the command record
// and the legality rule applied when a command is taken from the host.
package nonlinear_pkg;

  typedef enum logic [3:0] {
    softmax         = 4'd0,
    sigmoid         = 4'd1,
    tanh            = 4'd2,
    relu            = 4'd3,
    pooling         = 4'd4,
    average_pooling = 4'd5
  } operation_e;

  localparam logic [3:0] OP_MAX = 4'(average_pooling);

  // op is kept as a raw 4-bit code so out-of-range values survive until validation
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  bubble;
    logic [1:0]  continuity;
    logic [9:0]  din_length;
    logic [15:0] din_addr;
    logic [3:0]  win_length;
    logic [5:0]  win_addr;
    logic [15:0] dout_addr;
  } nl_cmd_t;

  function automatic logic cmd_is_legal(input nl_cmd_t cmd);
    return (cmd.op <= OP_MAX) && (cmd.din_length != '0);
  endfunction

endpackage

// File: rtl/nonlinear_cmd_issuer_if.sv
// Valid/ready command bus carrying one nl_cmd_t; master drives valid and the command.
interface nonlinear_cmd_issuer_if;
  import nonlinear_pkg::*;

  logic    valid;
  logic    ready;
  nl_cmd_t cmd;

  modport master (output valid, output cmd, input ready);
  modport slave  (input valid, input cmd, output ready);

endinterface

// File: rtl/nl_cmd_fifo.sv
// Synchronous FIFO of nl_cmd_t with flush; flush overrides push and pop in the same cycle.
module nl_cmd_fifo
  import nonlinear_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  nl_cmd_t                wr_data,
  input  logic                   pop,
  output nl_cmd_t                rd_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  nl_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr_reg];

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/nonlinear_cmd_issuer.sv
// Queues host commands, drops illegal ones, and presents each to the nonlinear
// controller with a valid/ready handshake followed by a mandatory one-cycle gap.
module nonlinear_cmd_issuer
  import nonlinear_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nonlinear_cmd_issuer_if.slave  host,
  nonlinear_cmd_issuer_if.master nl,
  input  logic                   flush,
  input  logic                   err_clear,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic                   err_illegal,
  output logic                   idle
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_e;

  state_e           state_reg;
  logic             nl_valid_reg;
  nl_cmd_t          nl_cmd_reg;
  logic [CNT_W-1:0] issued_cnt_reg;
  logic             err_reg;

  logic    fifo_full;
  logic    fifo_empty;
  logic    host_accept;
  logic    cmd_legal;
  logic    fifo_push;
  logic    fifo_pop;
  logic    err_set;
  nl_cmd_t fifo_head;

  // An accept is acknowledged even when the command is dropped afterwards
  assign host.ready  = !fifo_full;
  assign host_accept = host.valid && !fifo_full;
  assign cmd_legal   = cmd_is_legal(host.cmd);
  assign fifo_push   = host_accept && cmd_legal && !flush;
  assign err_set     = host_accept && !cmd_legal && !flush;
  assign fifo_pop    = (state_reg == S_IDLE) && !fifo_empty && !flush;

  nl_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (host.cmd),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      nl_valid_reg   <= 1'b0;
      nl_cmd_reg     <= '0;
      issued_cnt_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= (err_reg && !err_clear) || err_set;
      case (state_reg)
        S_IDLE: begin
          if (fifo_pop) begin
            nl_cmd_reg   <= fifo_head;
            nl_valid_reg <= 1'b1;
            state_reg    <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Fields stay frozen until the controller takes them; flush cannot retract
          if (nl.ready) begin
            issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
            nl_valid_reg   <= 1'b0;
            state_reg      <= S_GAP;
          end
        end
        S_GAP: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign nl.valid    = nl_valid_reg;
  assign nl.cmd      = nl_cmd_reg;
  assign issued_cnt  = issued_cnt_reg;
  assign err_illegal = err_reg;
  assign idle        = (fifo_count == '0) && !nl_valid_reg && (state_reg != S_GAP);

endmodule

// File: tb/tb_nonlinear_cmd_issuer.sv
// Bench for nonlinear_cmd_issuer: directed sequences, a legality table and a
// randomized run checked against a queue-based transaction model.
module tb_nonlinear_cmd_issuer;
  import nonlinear_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic err_clear;
  logic [2:0] fifo_count;
  logic [CNT_W-1:0] issued_cnt;
  logic err_illegal;
  logic idle;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nonlinear_cmd_issuer_if host_bus();
  nonlinear_cmd_issuer_if nl_bus();

  nonlinear_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host_bus),
    .nl          (nl_bus),
    .flush       (flush),
    .err_clear   (err_clear),
    .fifo_count  (fifo_count),
    .issued_cnt  (issued_cnt),
    .err_illegal (err_illegal),
    .idle        (idle)
  );

  typedef struct {
    logic [3:0] op;
    logic [9:0] len;
    logic       exp_issue;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic nl_cmd_t mk_cmd(input logic [3:0] op, input logic [9:0] len,
                                     input logic [15:0] addr);
    nl_cmd_t c;
    c.op = op;
    c.bubble = 4'd2;
    c.continuity = 2'd1;
    c.din_length = len;
    c.din_addr = addr;
    c.win_length = 4'd3;
    c.win_addr = 6'h15;
    c.dout_addr = addr ^ 16'h8000;
    return c;
  endfunction

  task automatic push_cmd(input nl_cmd_t c);
    logic rdy;
    rdy = 1'b0;
    host_bus.valid = 1'b1;
    host_bus.cmd = c;
    for (int g = 0; g < 50; g++) begin
      rdy = host_bus.ready;
      tick();
      if (rdy) break;
    end
    host_bus.valid = 1'b0;
    check("push_accept", 64'(rdy), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_bus.valid = 1'b0;
    nl_bus.ready = 1'b0;
    flush = 1'b0;
    err_clear = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    nl_cmd_t c;
    nl_cmd_t f[6];
    nl_cmd_t got_q[$];
    nl_cmd_t mq[$];
    vec_t vecs[7];
    logic stable;
    logic seen;
    logic [CNT_W-1:0] base;
    int issued_exp;
    logic err_exp;
    logic prev_hs;

    host_bus.cmd = '0;

    // 1: reset state
    do_reset();
    check("rst_nl_valid", 64'(nl_bus.valid), 64'd0);
    check("rst_issued", 64'(issued_cnt), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_host_ready", 64'(host_bus.ready), 64'd1);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_err", 64'(err_illegal), 64'd0);
    check("rst_nl_cmd", 64'(nl_bus.cmd), 64'd0);
    rst = 1'b0;
    tick();

    // 2: single relu command, two-cycle latency then a gap
    nl_bus.ready = 1'b1;
    c = mk_cmd(4'(relu), 10'd64, 16'h0100);
    push_cmd(c);
    check("t2_lat1_valid", 64'(nl_bus.valid), 64'd0);
    check("t2_lat1_count", 64'(fifo_count), 64'd1);
    tick();
    check("t2_valid", 64'(nl_bus.valid), 64'd1);
    check("t2_fields", 64'(nl_bus.cmd), 64'(c));
    tick();
    check("t2_gap_valid", 64'(nl_bus.valid), 64'd0);
    check("t2_issued", 64'(issued_cnt), 64'd1);
    check("t2_gap_idle", 64'(idle), 64'd0);
    tick();
    check("t2_idle", 64'(idle), 64'd1);

    // 3: backpressure holds the command stable
    nl_bus.ready = 1'b0;
    c = mk_cmd(4'(sigmoid), 10'd300, 16'hBEEF);
    push_cmd(c);
    tick();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!nl_bus.valid || nl_bus.cmd != c) stable = 1'b0;
      tick();
    end
    check("t3_hold", 64'(stable && nl_bus.valid && nl_bus.cmd == c), 64'd1);
    nl_bus.ready = 1'b1;
    tick();
    check("t3_release_valid", 64'(nl_bus.valid), 64'd0);
    tick();
    tick();
    check("t3_one_transfer", 64'(issued_cnt), 64'd2);
    check("t3_no_repeat", 64'(nl_bus.valid), 64'd0);
    nl_bus.ready = 1'b0;

    // 4: fill the queue behind a stalled presentation
    for (int i = 0; i < 6; i++) f[i] = mk_cmd(4'(i % 6), 10'(i + 1), 16'(16'h2000 + i));
    for (int i = 0; i < 5; i++) push_cmd(f[i]);
    check("t4_count_full", 64'(fifo_count), 64'd4);
    check("t4_host_ready", 64'(host_bus.ready), 64'd0);
    check("t4_presented", 64'(nl_bus.cmd), 64'(f[0]));
    host_bus.valid = 1'b1;
    host_bus.cmd = f[5];
    for (int i = 0; i < 3; i++) tick();
    host_bus.valid = 1'b0;
    check("t4_stalled_count", 64'(fifo_count), 64'd4);
    nl_bus.ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      if (nl_bus.valid) got_q.push_back(nl_bus.cmd);
      tick();
    end
    check("t4_drain_n", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check("t4_order", 64'(got_q[i]), 64'(f[i]));
    end
    check("t4_issued", 64'(issued_cnt), 64'd7);

    // 5: illegal commands are dropped and flagged
    base = issued_cnt;
    push_cmd(mk_cmd(4'd7, 10'd10, 16'h3000));
    check("t5_err_op", 64'(err_illegal), 64'd1);
    check("t5_not_queued", 64'(fifo_count), 64'd0);
    push_cmd(mk_cmd(4'(relu), 10'd0, 16'h3001));
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_issue_valid", 64'(nl_bus.valid), 64'd0);
    check("t5_issued_same", 64'(issued_cnt), 64'(base));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t5_err_cleared", 64'(err_illegal), 64'd0);
    err_clear = 1'b1;
    push_cmd(mk_cmd(4'd9, 10'd5, 16'h3002));
    err_clear = 1'b0;
    check("t5_set_beats_clear", 64'(err_illegal), 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // 6: flush while presenting
    nl_bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(mk_cmd(4'(i), 10'(20 + i), 16'(16'h4000 + i)));
    f[0] = mk_cmd(4'd0, 10'd20, 16'h4000);
    check("t6_queued", 64'(fifo_count), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flushed", 64'(fifo_count), 64'd0);
    check("t6_still_valid", 64'(nl_bus.valid), 64'd1);
    check("t6_still_cmd", 64'(nl_bus.cmd), 64'(f[0]));
    flush = 1'b1;
    host_bus.valid = 1'b1;
    host_bus.cmd = mk_cmd(4'd1, 10'd7, 16'h4100);
    tick();
    flush = 1'b0;
    host_bus.valid = 1'b0;
    check("t6_flush_wins", 64'(fifo_count), 64'd0);
    check("t6_flush_err", 64'(err_illegal), 64'd0);
    base = issued_cnt;
    nl_bus.ready = 1'b1;
    tick();
    tick();
    tick();
    check("t6_issued", 64'(issued_cnt), 64'(base + 16'd1));
    check("t6_idle", 64'(idle), 64'd1);

    // legality table
    vecs[0] = '{4'd0, 10'd1, 1'b1, 1'b0};
    vecs[1] = '{4'd5, 10'd1023, 1'b1, 1'b0};
    vecs[2] = '{4'd6, 10'd5, 1'b0, 1'b1};
    vecs[3] = '{4'd15, 10'd5, 1'b0, 1'b1};
    vecs[4] = '{4'd3, 10'd0, 1'b0, 1'b1};
    vecs[5] = '{4'd4, 10'd2, 1'b1, 1'b0};
    vecs[6] = '{4'd2, 10'd0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      base = issued_cnt;
      c = mk_cmd(vecs[i].op, vecs[i].len, 16'(16'h5000 + i));
      push_cmd(c);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (nl_bus.valid && nl_bus.cmd == c) seen = 1'b1;
        tick();
      end
      check("tbl_issued", 64'(issued_cnt - base), 64'(vecs[i].exp_issue));
      check("tbl_err", 64'(err_illegal), 64'(vecs[i].exp_err));
      check("tbl_seen", 64'(seen), 64'(vecs[i].exp_issue));
    end

    // randomized run against a transaction model
    do_reset();
    rst = 1'b0;
    mq.delete();
    issued_exp = 0;
    err_exp = 1'b0;
    prev_hs = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic quiet, v_b, hs, rise, exp_rise, acc, legal;
      nl_cmd_t rc, c_b, exp_c;
      quiet = (cyc >= 2950);
      rc.op = 4'($urandom_range(0, 7));
      rc.bubble = 4'($urandom);
      rc.continuity = 2'($urandom);
      rc.din_length = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      rc.din_addr = 16'($urandom);
      rc.win_length = 4'($urandom);
      rc.win_addr = 6'($urandom);
      rc.dout_addr = 16'($urandom);
      host_bus.cmd = rc;
      host_bus.valid = quiet ? 1'b0 : 1'($urandom_range(0, 1));
      nl_bus.ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      flush = !quiet && ($urandom_range(0, 39) == 0);
      err_clear = !quiet && ($urandom_range(0, 24) == 0);
      check("rnd_host_ready", 64'(host_bus.ready), 64'(mq.size() < DEPTH));
      v_b = nl_bus.valid;
      c_b = nl_bus.cmd;
      acc = host_bus.valid && (mq.size() < DEPTH);
      legal = (rc.op < 4'd6) && (rc.din_length != 10'd0);
      exp_rise = !v_b && !prev_hs && (mq.size() > 0) && !flush;
      tick();
      hs = v_b && nl_bus.ready;
      rise = nl_bus.valid && !v_b;
      check("rnd_present", 64'(rise), 64'(exp_rise));
      if (rise && mq.size() > 0) begin
        exp_c = mq.pop_front();
        check("rnd_order", 64'(nl_bus.cmd), 64'(exp_c));
      end
      if (v_b && !hs) check("rnd_hold", 64'(nl_bus.valid && nl_bus.cmd == c_b), 64'd1);
      if (hs) begin
        issued_exp++;
        check("rnd_gap", 64'(nl_bus.valid), 64'd0);
      end
      if (flush) mq.delete();
      else if (acc && legal) mq.push_back(rc);
      err_exp = (err_exp && !err_clear) || (acc && !legal && !flush);
      check("rnd_count", 64'(fifo_count), 64'(mq.size()));
      check("rnd_issued", 64'(issued_cnt), 64'(16'(issued_exp)));
      check("rnd_err", 64'(err_illegal), 64'(err_exp));
      check("rnd_idle", 64'(idle), 64'((mq.size() == 0) && !nl_bus.valid && !hs));
      prev_hs = hs;
    end
    flush = 1'b0;
    err_clear = 1'b0;
    check("rnd_final_idle", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
